// File: rtl/rr_arb_4to1.sv
// -----------------------------------------------------------------------------
// rr_arb_4to1
//
// Round-robin arbiter plus output register for four WIDTH-bit request
// channels. It drives the 2-bit select of the downstream 4:1 mux and registers
// the granted word onto one valid/ready output channel.
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   4      bit i: channel i presents a word
//   in_data_a  in   WIDTH  channel 0 data
//   in_data_b  in   WIDTH  channel 1 data
//   in_data_c  in   WIDTH  channel 2 data
//   in_data_d  in   WIDTH  channel 3 data
//   in_ready   out  4      bit i: channel i's word is accepted this cycle
//   sel        out  2      index of the channel held in the output register
//   out_valid  out  1      output register holds a word
//   out_data   out  WIDTH  registered word
//   out_ready  in   1      consumer accepts out_data this cycle
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high on that interface. Valid never waits on ready
// here. in_ready is combinational from in_valid, out_valid and out_ready.
// While out_valid && !out_ready, out_data and sel stay stable.
// -----------------------------------------------------------------------------
module rr_arb_4to1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic [WIDTH-1:0] in_data_c,
  input  logic [WIDTH-1:0] in_data_d,
  output logic [3:0]       in_ready,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Index of the most recent grant. The search starts one past it.
  logic [1:0]       last;
  logic             ld;
  logic             has_win;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] win_data;

  // The output register can take a new word when empty or being drained.
  assign ld = !out_valid || out_ready;

  // Rotating priority search: last+1, last+2, last+3, then last itself.
  // The 2-bit add wraps 3->0, so k=4 lands back on last.
  always_comb begin
    has_win = 1'b0;
    win     = last;
    idx     = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!has_win && in_valid[idx]) begin
        has_win = 1'b1;
        win     = idx;
      end
    end
  end

  // The mux is steered only by the winner index, which depends solely on
  // in_valid. An invalid channel's data therefore cannot reach any output.
  always_comb begin
    win_data = in_data_a;
    case (win)
      2'd0:    win_data = in_data_a;
      2'd1:    win_data = in_data_b;
      2'd2:    win_data = in_data_c;
      default: win_data = in_data_d;
    endcase
  end

  assign in_ready = (ld && has_win) ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 2'd0;
      last      <= 2'd3;
    end else if (ld) begin
      if (has_win) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        sel       <= win;
        last      <= win;
      end else begin
        // Drained with nothing to replace it. Data, sel and pointer hold.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_4to1.sv
module tb_rr_arb_4to1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = 4'b0;
  logic [31:0] in_data_a = '0, in_data_b = '0, in_data_c = '0, in_data_d = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        out_valid;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  rr_arb_4to1 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_a (in_data_a),
    .in_data_b (in_data_b),
    .in_data_c (in_data_c),
    .in_data_d (in_data_d),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic        m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_sel;
  logic [1:0]  m_last;
  logic [31:0] exp_q[$];
  int          wait_cnt[4];
  int          g_win;   // grant taken on the most recent edge, -1 if none

  function automatic int pick(input logic [3:0] v, input logic [1:0] lst);
    int i;
    i = (int'(lst) + 1) % 4;
    repeat (4) begin
      if (v[i]) return i;
      i = (i + 1) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] chan_data(input int w);
    case (w)
      0:       return in_data_a;
      1:       return in_data_b;
      2:       return in_data_c;
      default: return in_data_d;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 2'd0;
    m_last  = 2'd3;
    exp_q.delete();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // One clock cycle. Inputs are set by the caller at posedge+1; checks run at
  // the negedge; the model advances on the posedge; returns at posedge+1.
  task automatic cycle();
    int          w;
    logic        ld;
    logic [3:0]  exp_rdy;
    logic [31:0] wd;
    @(negedge clk);
    ld      = !m_valid || out_ready;
    w       = pick(in_valid, m_last);
    exp_rdy = (ld && w >= 0) ? 4'(1 << w) : 4'b0000;
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("sel",       32'(sel),       32'(m_sel));
    check("out_data",  out_data,       m_data);
    if (m_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
    end
    wd = (w >= 0) ? chan_data(w) : 32'd0;
    if (ld && w >= 0) exp_q.push_back(wd);
    for (int i = 0; i < 4; i++) begin
      if (ld && w == i) begin
        check("fair_gap", 32'(wait_cnt[i] > 3), 32'd0);
        wait_cnt[i] = 0;
      end else if (in_valid[i]) begin
        if (ld && w >= 0) wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
    end
    @(posedge clk);
    g_win = -1;
    if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = wd;
        m_sel   = 2'(w);
        m_last  = 2'(w);
        g_win   = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic        src_v[4];
  logic [31:0] src_d[4];
  int          seq[4];

  initial begin
    model_reset();
    g_win = -1;

    // 1. reset state and asynchronous mid-cycle reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_sel",       32'(sel),       32'd0);
    rst = 1'b0;

    in_valid  = 4'b1111;
    in_data_a = 32'h11; in_data_b = 32'h12; in_data_c = 32'h13; in_data_d = 32'h14;
    out_ready = 1'b0;
    repeat (2) cycle();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_data",  out_data,       32'h11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data",  out_data,       32'd0);
    check("async_rst_sel",   32'(sel),       32'd0);
    model_reset();
    in_valid = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;

    // 2. all channels request, consumer always ready
    in_valid  = 4'b1111;
    in_data_a = 32'hA0; in_data_b = 32'hA1; in_data_c = 32'hA2; in_data_d = 32'hA3;
    out_ready = 1'b1;
    #1;
    check("t2_first_grant", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t2_data", out_data, 32'hA0 + 32'(k % 4));
      check("t2_sel",  32'(sel), 32'(k % 4));
    end

    // 3. backpressure holds word and selection
    in_valid  = 4'b0001;
    in_data_a = 32'hDEADBEEF;
    cycle();
    check("t3_load", out_data, 32'hDEADBEEF);
    in_valid  = 4'b1111;
    in_data_a = 32'hB0; in_data_b = 32'hB1; in_data_c = 32'hB2; in_data_d = 32'hB3;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_rdy", 32'(in_ready), 32'd0);
      cycle();
      check("t3_stall_data", out_data, 32'hDEADBEEF);
      check("t3_stall_sel",  32'(sel), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_rdy", 32'(in_ready), 32'b0010);
    cycle();
    check("t3_release_data", out_data, 32'hB1);
    check("t3_release_sel",  32'(sel), 32'd1);

    // 4. sparse requests after last=1
    in_valid  = 4'b1010;
    in_data_b = 32'hC1; in_data_d = 32'hC3;
    #1;
    check("t4_rdy0", 32'(in_ready), 32'b1000);
    cycle();
    check("t4_sel0", 32'(sel), 32'd3);
    check("t4_data0", out_data, 32'hC3);
    check("t4_rdy1", 32'(in_ready), 32'b0010);
    cycle();
    check("t4_sel1", 32'(sel), 32'd1);
    cycle();
    check("t4_sel2", 32'(sel), 32'd3);

    // 5. single channel streaming, other data lines undriven
    in_valid  = 4'b0100;
    in_data_a = 'x; in_data_b = 'x; in_data_d = 'x;
    for (int k = 0; k < 10; k++) begin
      in_data_c = 32'(k);
      cycle();
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_data",  out_data,       32'(k));
      check("t5_sel",   32'(sel),       32'd2);
    end

    // 6. random sources (hold valid until accepted) and random backpressure
    for (int i = 0; i < 4; i++) begin
      src_v[i] = 1'b0;
      src_d[i] = '0;
      seq[i]   = 0;
    end
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!src_v[i] && $urandom_range(0, 1) == 1) begin
          src_v[i] = 1'b1;
          src_d[i] = (32'(i) << 24) | 32'h005A_0000 | 32'(seq[i]);
          seq[i]++;
        end
      end
      in_valid  = {src_v[3], src_v[2], src_v[1], src_v[0]};
      in_data_a = src_d[0]; in_data_b = src_d[1];
      in_data_c = src_d[2]; in_data_d = src_d[3];
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (g_win >= 0) src_v[g_win] = 1'b0;
    end

    // drain everything still in flight
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle",  32'(out_valid),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
